// File: rtl/rsa_byte_link_pkg.sv
// Shared types and constants for the RSA byte link: FSM states and frame geometry.
package rsa_byte_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    START,
    WAIT,
    SEND,
    ERR
  } state_t;

  localparam int         FRAME_BYTES      = 12;
  localparam int         RESULT_BYTES     = 4;
  localparam logic [7:0] DEFAULT_ERR_CODE = 8'hEE;

endpackage

// File: rtl/rsa_byte_ser.sv
// Byte serializer: loads a 32-bit word and emits it MSB byte first over valid/ready.
module rsa_byte_ser
  import rsa_byte_link_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        last
);

  localparam int CW = $clog2(RESULT_BYTES + 1);

  logic [31:0]   shreg;
  logic [CW-1:0] remaining;

  // The shift register doubles as the captured-result register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg     <= '0;
      remaining <= '0;
    end else if (load) begin
      shreg     <= load_data;
      remaining <= CW'(RESULT_BYTES);
    end else if (tx_valid && tx_ready) begin
      shreg     <= {shreg[23:0], 8'h00};
      remaining <= remaining - CW'(1);
    end
  end

  assign tx_valid = (remaining != '0);
  assign tx_data  = shreg[31:24];
  assign last     = tx_valid && tx_ready && (remaining == CW'(1));

endmodule

// File: rtl/rsa_byte_link.sv
// Byte-stream front end for an RSA core: collects a 12-byte text/key/mod frame,
// validates it, runs the core with a timeout and returns the 4-byte result or an error code.
module rsa_byte_link
  import rsa_byte_link_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 4096,
  parameter logic [7:0] ERR_CODE       = DEFAULT_ERR_CODE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] rsa_text,
  output logic [31:0] rsa_key,
  output logic [31:0] rsa_mod,
  output logic        rsa_go,
  input  logic        rsa_done,
  input  logic [31:0] rsa_result,
  output logic        busy,
  output logic        err
);

  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state, next_state;
  logic [3:0]    byte_cnt;
  logic [WW-1:0] wait_cnt;
  logic          err_seen;
  logic          rx_fire;
  logic          ser_load, ser_valid, ser_last;
  logic [7:0]    ser_data;

  assign rx_fire = rx_valid && rx_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (rx_fire) next_state = LOAD;
      LOAD:  if (rx_fire && byte_cnt == 4'(FRAME_BYTES - 1)) next_state = CHECK;
      CHECK: begin
        if (!rsa_mod[0] || rsa_mod < 32'd3 || rsa_text >= rsa_mod) next_state = ERR;
        else                                                        next_state = START;
      end
      START: next_state = WAIT;
      WAIT: begin
        if (rsa_done)                                  next_state = SEND;
        else if (wait_cnt >= WW'(TIMEOUT_CYCLES - 1))  next_state = ERR;
      end
      SEND:  if (ser_last) next_state = IDLE;
      ERR:   if (tx_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Reset gates rx_ready so nothing is accepted while the block is held in reset.
  always_comb begin
    rx_ready = reset && (state == IDLE || state == LOAD);
    rsa_go   = (state == START);
    busy     = (state != IDLE);
    err      = (state == ERR) && !err_seen;
    ser_load = (state == WAIT) && rsa_done;
    tx_valid = 1'b0;
    tx_data  = '0;
    case (state)
      SEND: begin
        tx_valid = ser_valid;
        tx_data  = ser_data;
      end
      ERR: begin
        tx_valid = 1'b1;
        tx_data  = ERR_CODE;
      end
      default: ;
    endcase
  end

  // Frame bytes shift through text/key/mod as one 96-bit big-endian register;
  // wait_cnt holds the number of cycles since rsa_go.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsa_text <= '0;
      rsa_key  <= '0;
      rsa_mod  <= '0;
      byte_cnt <= '0;
      wait_cnt <= '0;
      err_seen <= 1'b0;
    end else begin
      err_seen <= (state == ERR);
      if (rx_fire) begin
        {rsa_text, rsa_key, rsa_mod} <= {rsa_text[23:0], rsa_key, rsa_mod, rx_data};
        byte_cnt <= (byte_cnt == 4'(FRAME_BYTES - 1)) ? 4'd0 : byte_cnt + 4'd1;
      end
      if (state == START)     wait_cnt <= WW'(1);
      else if (state == WAIT) wait_cnt <= wait_cnt + WW'(1);
    end
  end

  rsa_byte_ser u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (ser_load),
    .load_data (rsa_result),
    .tx_ready  (tx_ready),
    .tx_data   (ser_data),
    .tx_valid  (ser_valid),
    .last      (ser_last)
  );

endmodule

// File: tb/tb_rsa_byte_link.sv
// Randomized scoreboard bench for rsa_byte_link with an RSA core stub and a frame-level reference model.
module tb_rsa_byte_link;
  import rsa_byte_link_pkg::*;

  localparam int TIMEOUT = 300;
  localparam logic [95:0] FRAME_OK   = 96'h00982af2_a51126c1_ae177305;
  localparam logic [95:0] FRAME_EVEN = 96'h00982af2_a51126c1_ae177304;
  localparam logic [95:0] FRAME_EQ   = 96'hae177305_a51126c1_ae177305;
  localparam logic [95:0] FRAME_SMALL = 96'h00000000_00000005_00000001;
  localparam logic [95:0] FRAME_PART = 96'h11223344_55667788_99aabbcd;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [31:0] rsa_text, rsa_key, rsa_mod;
  logic        rsa_go;
  logic        rsa_done = 1'b0;
  logic [31:0] rsa_result = 32'h0;
  logic        busy;
  logic        err;

  rsa_byte_link #(.TIMEOUT_CYCLES(TIMEOUT), .ERR_CODE(8'hEE)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rsa_text(rsa_text), .rsa_key(rsa_key), .rsa_mod(rsa_mod), .rsa_go(rsa_go),
    .rsa_done(rsa_done), .rsa_result(rsa_result), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  exp_tx[$];
  logic [95:0] exp_go[$];
  int          exp_err[$];

  int          stub_delay = 10;
  logic [31:0] stub_result = 32'h0;
  bit          stub_never = 1'b0;
  int          stall_pct = 0;
  int          last_rx_cyc = 0;
  int          last_go_cyc = 0;

  task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Frame-level reference: decides outcome from the frame fields and the stub's behaviour.
  task automatic expectFrame(input logic [95:0] frame);
    logic [31:0] t, m;
    t = frame[95:64];
    m = frame[31:0];
    if (m % 2 == 0 || m < 3 || t >= m) begin
      exp_err.push_back(0);
      exp_tx.push_back(8'hEE);
    end else begin
      exp_go.push_back(frame);
      if (stub_never) begin
        exp_err.push_back(1);
        exp_tx.push_back(8'hEE);
      end else begin
        exp_tx.push_back(8'((stub_result / 32'h0100_0000) % 256));
        exp_tx.push_back(8'((stub_result / 32'h0001_0000) % 256));
        exp_tx.push_back(8'((stub_result / 32'h0000_0100) % 256));
        exp_tx.push_back(8'(stub_result % 256));
      end
    end
  endtask

  task automatic sendBytes(input logic [95:0] frame, input int n, input int gap_pct, output bit ok);
    int waited;
    ok = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < 6 && $urandom_range(99) < gap_pct; g++) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(posedge clk); #1;
      end
      rx_valid = 1'b1;
      rx_data  = frame[95 - 8*i -: 8];
      waited = 0;
      @(negedge clk);
      while (!rx_ready && waited < 2000) begin
        waited++;
        @(negedge clk);
      end
      if (!rx_ready) begin
        checkOutput("rx_ready_wait", 96'(rx_ready), 96'd1);
        rx_valid = 1'b0;
        ok = 1'b0;
        return;
      end
      last_rx_cyc = cyc;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    int pending;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      pending = exp_tx.size() + exp_err.size() + exp_go.size();
    end while ((busy || pending != 0) && n < 3 * TIMEOUT);
    checkOutput("drain", {63'd0, busy, 32'(pending)}, 96'd0);
  endtask

  task automatic applyStimulus(input logic [95:0] frame, input int gap_pct, input int stall,
                               input bit never, input int delay, input logic [31:0] result);
    bit ok;
    stub_never  = never;
    stub_delay  = delay;
    stub_result = result;
    stall_pct   = stall;
    sendBytes(frame, 12, gap_pct, ok);
    if (ok) expectFrame(frame);
    waitIdle();
  endtask

  task automatic checkResetState();
    checkOutput("reset_rx_ready", 96'(rx_ready), 96'd0);
    checkOutput("reset_busy", 96'(busy), 96'd0);
    checkOutput("reset_tx", {87'd0, tx_valid, tx_data}, 96'd0);
    checkOutput("reset_go_err", {94'd0, rsa_go, err}, 96'd0);
    checkOutput("reset_words", {rsa_text, rsa_key, rsa_mod}, 96'd0);
  endtask

  // Core stub: raises rsa_done for one cycle stub_delay cycles after rsa_go.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && rsa_go && !stub_never) begin
        @(posedge clk);
        repeat (stub_delay - 1) @(posedge clk);
        #1;
        rsa_done   = 1'b1;
        rsa_result = stub_result;
        @(posedge clk); #1;
        rsa_done   = 1'b0;
        rsa_result = $urandom;
        @(negedge clk);
        checkOutput("tx_valid_after_capture", 96'(tx_valid), 96'd1);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      tx_ready = ($urandom_range(99) >= stall_pct);
    end
  end

  logic [95:0] go_exp;
  always @(negedge clk) begin
    if (reset && rsa_go) begin
      if (exp_go.size() == 0) begin
        checkOutput("unexpected_go", 96'(rsa_go), 96'd0);
      end else begin
        go_exp = exp_go.pop_front();
        checkOutput("go_text", 96'(rsa_text), 96'(go_exp[95:64]));
        checkOutput("go_key", 96'(rsa_key), 96'(go_exp[63:32]));
        checkOutput("go_mod", 96'(rsa_mod), 96'(go_exp[31:0]));
        checkOutput("go_latency", 96'(cyc - last_rx_cyc), 96'd2);
      end
      last_go_cyc = cyc;
    end
  end

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    if (reset) begin
      if (prev_stall) checkOutput("tx_hold_stable", {87'd0, tx_valid, tx_data}, {87'd0, 1'b1, prev_data});
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) checkOutput("unexpected_tx", 96'(tx_valid), 96'd0);
        else                    checkOutput("tx_byte", 96'(tx_data), 96'(exp_tx.pop_front()));
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  int err_kind;
  always @(negedge clk) begin
    if (reset && err) begin
      if (exp_err.size() == 0) begin
        checkOutput("unexpected_err", 96'(err), 96'd0);
      end else begin
        err_kind = exp_err.pop_front();
        if (err_kind == 1) checkOutput("timeout_cycles", 96'(cyc - last_go_cyc), 96'(TIMEOUT));
        checkOutput("err_tx_code", {87'd0, tx_valid, tx_data}, {87'd0, 1'b1, 8'hEE});
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    logic [31:0] t, k, m;
    #1;
    checkResetState();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rx_ready_after_release", 96'(rx_ready), 96'd1);

    applyStimulus(FRAME_OK, 0, 0, 1'b0, 50, 32'h12345678);
    applyStimulus(FRAME_EVEN, 0, 0, 1'b0, 50, 32'h12345678);
    applyStimulus(FRAME_EQ, 0, 0, 1'b0, 50, 32'h12345678);
    applyStimulus(FRAME_SMALL, 0, 0, 1'b0, 50, 32'h12345678);
    applyStimulus(FRAME_OK, 0, 0, 1'b1, 50, 32'h12345678);
    checkOutput("busy_after_timeout", 96'(busy), 96'd0);
    applyStimulus(FRAME_OK, 50, 50, 1'b0, 20, 32'h12345678);

    stall_pct = 0;
    sendBytes(FRAME_PART, 7, 0, ok);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    checkResetState();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("rx_ready_after_midframe_reset", 96'(rx_ready), 96'd1);
    applyStimulus(FRAME_OK, 0, 0, 1'b0, 50, 32'h12345678);

    for (int i = 0; i < 12; i++) begin
      t = $urandom;
      k = $urandom;
      m = $urandom;
      if ($urandom_range(3) != 0) begin
        m = m | 32'd1;
        t = t % m;
      end
      applyStimulus({t, k, m}, $urandom_range(60), $urandom_range(60),
                    ($urandom_range(7) == 0), $urandom_range(1, 60), $urandom);
    end

    checkOutput("go_queue_empty", 96'(exp_go.size()), 96'd0);
    checkOutput("tx_queue_empty", 96'(exp_tx.size()), 96'd0);
    checkOutput("err_queue_empty", 96'(exp_err.size()), 96'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rsa_byte_link.md
RSA_BYTE_LINK -- requirements
Module: rsa_byte_link

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning the max cycles from rsa_go to rsa_done before error.
REQ-002 SHALL have parameter ERR_CODE, default 8'hEE, meaning the byte sent on any error.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx_data  input  8  inbound byte.
REQ-006 SHALL have port rx_valid  input  1  inbound byte valid.
REQ-007 SHALL have port rx_ready  output  1  block accepts byte when rx_valid&&rx_ready.
REQ-008 SHALL have port tx_data  output  8  outbound byte.
REQ-009 SHALL have port tx_valid  output  1  outbound byte valid.
REQ-010 SHALL have port tx_ready  input  1  sink accepts when tx_valid&&tx_ready.
REQ-011 SHALL have port rsa_text  output  32  plaintext/ciphertext word to RSA core.
REQ-012 SHALL have port rsa_key  output  32  exponent word.
REQ-013 SHALL have port rsa_mod  output  32  modulus word.
REQ-014 SHALL have port rsa_go  output  1  one-cycle start pulse to RSA core.
REQ-015 SHALL have port rsa_done  input  1  RSA core completion flag (level or pulse).
REQ-016 SHALL have port rsa_result  input  32  RSA core output word, valid while rsa_done high.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-018 SHALL have port err  output  1  one-cycle pulse on bad modulus or timeout.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, CHECK, START, WAIT, SEND, ERR.
REQ-020 IDLE->LOAD on first accepted byte; that byte counts as byte 0.
REQ-021 LOAD SHALL accept 12 bytes, rx_ready=1 in IDLE/LOAD only, big-endian: bytes 0-3 text, 4-7 key, 8-11 mod; 4-bit byte counter; after byte 11 go to CHECK.
REQ-022 CHECK (1 cycle): mod[0]==0 or mod<3 or text>=mod -> ERR; else START.
REQ-023 START SHALL assert rsa_go for exactly one cycle with rsa_text/key/mod stable, then WAIT; rsa_text/key/mod SHALL hold until next LOAD begins.
REQ-024 WAIT SHALL ignore rsa_done during the START cycle; first cycle rsa_done=1 in WAIT captures rsa_result into a 32-bit register and goes to SEND.
REQ-025 WAIT SHALL count cycles; count reaching TIMEOUT_CYCLES without rsa_done -> ERR.
REQ-026 SEND SHALL emit result MSB byte first, 4 bytes, tx_valid held and tx_data stable until tx_ready; after 4th handshake -> IDLE.
REQ-027 ERR SHALL pulse err in its first cycle, present ERR_CODE with tx_valid until tx_ready, then IDLE.
REQ-028 Zero-wait back-to-back: tx_valid&&tx_ready every cycle SHALL give one byte per cycle; same for rx.
REQ-029 rx_valid while not ready (CHECK..ERR) SHALL not be consumed; no byte loss.
REQ-030 Latency: rsa_go SHALL assert 2 cycles after byte 11 accepted; first tx_valid 1 cycle after capture.

Reset
REQ-031 reset low SHALL asynchronously force IDLE, counters 0, rsa_go=0, tx_valid=0, err=0, busy=0, tx_data=0, rsa_text/key/mod=0, captured result=0.
REQ-032 Reset mid-LOAD/WAIT/SEND SHALL discard partial frame; next frame starts at byte 0 after release.
REQ-033 rx_ready SHALL be 0 during reset and 1 in the first cycle after release.

Structure
REQ-034 Shared package SHALL hold FSM state enum, FRAME_BYTES=12, RESULT_BYTES=4, default ERR_CODE.
REQ-035 One sub-module rsa_byte_ser (32-bit load, valid/ready byte serializer, MSB first) SHALL implement SEND; the rest is flat.

Verification
REQ-036 Frame 00 98 2a f2 a5 11 26 c1 ae 17 73 05, core stub returns 0x12345678 after 50 cycles -> rsa_go one pulse with text=0x00982af2, key=0xa51126c1, mod=0xae177305; tx 12 34 56 78.
REQ-037 Same frame with mod=0xae177304 (even) -> err pulse, tx EE only, rsa_go never asserted.
REQ-038 Valid frame, core stub never asserts done -> err at TIMEOUT_CYCLES after rsa_go, tx EE, busy drops.
REQ-039 Random rx_valid gaps and tx_ready stalls (50%) -> identical bytes 12 34 56 78, no drop or duplicate.
REQ-040 reset low after byte 6, then full valid frame -> only second frame's values reach core; single response.
REQ-041 text=0xae177305 equal to mod -> err, tx EE.
